// File: rtl/db_pkg.sv
// Shared formats, constants and state encoding for the dB-to-linear converter.
// Also builds the 2^(2^-i) coefficient table at elaboration time.
package db_pkg;

  localparam int INT_W    = 8;
  localparam int FRAC_W   = 24;
  localparam int ACC_FRAC = 30;
  localparam int ACC_W    = 32;

  localparam logic [23:0] K_LOG2_10_DIV10 = 24'd5573271;
  localparam logic [31:0] SAT_VAL         = 32'hFFFF_FFFF;
  localparam logic [31:0] ACC_ONE         = 32'h4000_0000;

  typedef enum logic [2:0] {
    IDLE,
    SCALE,
    EXP,
    NORM,
    DONE
  } state_e;

  typedef logic [FRAC_W:1][ACC_W-1:0] c_lut_t;

  function automatic logic [63:0] sqrt_round(input logic [63:0] x);
    logic [63:0] rem;
    logic [63:0] res;
    logic [63:0] b;
    rem = x;
    res = 64'd0;
    for (int k = 31; k >= 0; k--) begin
      b = 64'd1 << (2 * k);
      if (rem >= res + b) begin
        rem = rem - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
    end
    // rem now holds x - res^2; round half-up against (res + 0.5)^2.
    if (rem > res) res = res + 64'd1;
    return res;
  endfunction

  // C[i] = round(2^(2^-i) * 2^30), obtained by repeated square roots of 2.0.
  function automatic c_lut_t gen_c_lut();
    c_lut_t      lut;
    logic [63:0] prev;
    prev = 64'd1 << 31;
    for (int i = 1; i <= FRAC_W; i++) begin
      prev   = sqrt_round(prev << ACC_FRAC);
      lut[i] = prev[ACC_W-1:0];
    end
    return lut;
  endfunction

  localparam c_lut_t C_LUT = gen_c_lut();

endpackage

// File: rtl/db_to_linear_exp2.sv
// Iterative 2^f evaluator: multiplies a Q2.30 accumulator by 2^(2^-i) for each
// set fraction bit, MSB first, one bit per cycle.
module exp2_frac_iter
  import db_pkg::*;
#(
  parameter int FRAC_ITERS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [FRAC_W-1:0] f_i,
  output logic              done_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FRAC_W-1:0] f_q, f_d;
  logic [4:0]        idx_q, idx_d;
  logic              run_q, run_d;
  logic [ACC_W-1:0]  coef;
  logic [ACC_W-1:0]  acc_step;

  assign coef     = C_LUT[idx_q];
  assign acc_step = ACC_W'(((64'(acc_q) * 64'(coef)) + (64'd1 << (ACC_FRAC - 1))) >> ACC_FRAC);
  assign done_o   = run_q && (idx_q == 5'(FRAC_ITERS));
  assign acc_o    = acc_q;

  always_comb begin
    acc_d = acc_q;
    f_d   = f_q;
    idx_d = idx_q;
    run_d = run_q;
    if (start_i) begin
      acc_d = ACC_ONE;
      f_d   = f_i;
      idx_d = 5'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      // The fraction is shifted so its current bit is always the MSB.
      if (f_q[FRAC_W-1]) acc_d = acc_step;
      f_d   = f_q << 1;
      idx_d = idx_q + 5'd1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      f_q   <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      f_q   <= f_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/db_to_linear.sv
// Converts a Q8.24 dB value to integer linear power round(10^(y/10)) via
// 2^(y*log2(10)/10): scale, iterative 2^frac, then shift by the integer part.
module db_to_linear
  import db_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FRAC_ITERS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] db_in,
  input  logic             enable_in,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] lin_out
);

  localparam int P_W = WIDTH + FRAC_W;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [INT_W-1:0] n_q, n_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] lin_q, lin_d;

  logic [P_W-1:0]   p_scaled;
  logic [WIDTH-1:0] t_scaled;
  logic             exp_start;
  logic             exp_done;
  logic [ACC_W-1:0] exp_acc;

  function automatic logic [WIDTH-1:0] norm_sat(input logic [ACC_W-1:0] acc,
                                                input logic [INT_W-1:0] n);
    logic [63:0] r;
    if (n >= INT_W'(32)) return SAT_VAL;
    r = (64'(acc) << n[4:0]) + (64'd1 << (ACC_FRAC - 1));
    r = r >> ACC_FRAC;
    if (r[63:32] != 32'd0) return SAT_VAL;
    return r[31:0];
  endfunction

  // t = y * log2(10)/10 in Q8.24; integer part n, fraction f.
  assign p_scaled = P_W'(db_q) * P_W'(K_LOG2_10_DIV10);
  assign t_scaled = WIDTH'(p_scaled >> FRAC_W);

  exp2_frac_iter #(
    .FRAC_ITERS(FRAC_ITERS)
  ) u_exp2 (
    .clk    (clk),
    .rst    (rst),
    .start_i(exp_start),
    .f_i    (t_scaled[FRAC_W-1:0]),
    .done_o (exp_done),
    .acc_o  (exp_acc)
  );

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    n_d       = n_q;
    lin_d     = lin_q;
    valid_d   = 1'b0;
    exp_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (enable_in) begin
          db_d    = db_in;
          state_d = SCALE;
        end else begin
          state_d = IDLE;
        end
      end
      SCALE: begin
        n_d       = t_scaled[FRAC_W +: INT_W];
        exp_start = 1'b1;
        state_d   = EXP;
      end
      EXP: begin
        if (exp_done) state_d = NORM;
      end
      NORM: begin
        lin_d   = norm_sat(exp_acc, n_q);
        valid_d = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCALE) || (state_d == EXP) || (state_d == NORM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      db_q    <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      lin_q   <= '0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      lin_q   <= lin_d;
    end
  end

  assign busy      = busy_q;
  assign valid_out = valid_q;
  assign lin_out   = lin_q;

endmodule

// File: tb/tb_db_to_linear.sv
// Directed bench for db_to_linear: reset, known conversions, saturation,
// handshake corner cases, mid-conversion reset and a dB sweep against 10^(y/10).
module tb_db_to_linear;

  logic        clk;
  logic        rst;
  logic [31:0] db_in;
  logic        enable_in;
  logic        busy;
  logic        valid_out;
  logic [31:0] lin_out;

  int checks;
  int fails;

  db_to_linear #(
    .WIDTH     (32),
    .FRAC_ITERS(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .db_in    (db_in),
    .enable_in(enable_in),
    .busy     (busy),
    .valid_out(valid_out),
    .lin_out  (lin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One conversion; lat = negedges from the enable edge until valid_out, -1 if none.
  task automatic run_conv(input logic [31:0] db, output logic [31:0] lin,
                          output int lat, output int busy_cnt);
    bit found;
    @(negedge clk);
    db_in     = db;
    enable_in = 1'b1;
    @(posedge clk);
    #1;
    enable_in = 1'b0;
    lat       = -1;
    busy_cnt  = 0;
    lin       = 32'd0;
    found     = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (valid_out) begin
        lat   = k;
        lin   = lin_out;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    logic [31:0] lin, lin1, lin2;
    int          lat, bcnt, vcnt, k1, k2, busy_after;
    real         y, ideal, tol, diff;
    logic        ok;

    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    db_in     = 32'd0;
    enable_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, valid_out}, 64'd0);
    chk("reset_lin", {32'd0, lin_out}, 64'd0);
    rst = 1'b0;

    run_conv(32'h0000_0000, lin, lat, bcnt);
    chk("db0_lin", {32'd0, lin}, 64'd1);
    chk("db0_latency", 64'(lat), 64'd19);
    chk("db0_busy_cycles", 64'(bcnt), 64'd18);

    run_conv(32'h1E00_0000, lin, lat, bcnt);
    chk("db30_lin", {32'd0, lin}, 64'd1000);
    run_conv(32'h0302_A305, lin, lat, bcnt);
    chk("db3p0103_lin", {32'd0, lin}, 64'd2);
    run_conv(32'h0A00_0000, lin, lat, bcnt);
    chk("db10_lin", {32'd0, lin}, 64'd10);
    run_conv(32'h1400_0000, lin, lat, bcnt);
    chk("db20_lin", {32'd0, lin}, 64'd100);

    // 10^9.6 = 3981071706; 2^-14 relative is about 242985.
    run_conv(32'h6000_0000, lin, lat, bcnt);
    ok = (lin >= 32'd3980828721) && (lin <= 32'd3981314691);
    chk("db96_in_tol", {63'd0, ok}, 64'd1);
    run_conv(32'h6400_0000, lin, lat, bcnt);
    chk("db100_sat", {32'd0, lin}, 64'hFFFF_FFFF);
    run_conv(32'hFFFF_FFFF, lin, lat, bcnt);
    chk("dbmax_sat", {32'd0, lin}, 64'hFFFF_FFFF);

    // Enable pulses while busy must be ignored.
    @(negedge clk);
    db_in     = 32'h0A00_0000;
    enable_in = 1'b1;
    @(posedge clk);
    #1;
    enable_in = 1'b0;
    vcnt = 0;
    lat  = -1;
    lin1 = 32'd0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (valid_out) begin
        vcnt++;
        if (vcnt == 1) begin
          lat  = k;
          lin1 = lin_out;
        end
      end
      enable_in = (k == 3) || (k == 10);
      db_in     = 32'h1E00_0000;
    end
    enable_in = 1'b0;
    chk("busy_enable_valid_count", 64'(vcnt), 64'd1);
    chk("busy_enable_latency", 64'(lat), 64'd19);
    chk("busy_enable_lin", {32'd0, lin1}, 64'd10);

    // Enable during DONE starts the next conversion immediately.
    @(negedge clk);
    db_in     = 32'h1400_0000;
    enable_in = 1'b1;
    @(posedge clk);
    #1;
    enable_in  = 1'b0;
    vcnt       = 0;
    k1         = -1;
    k2         = -1;
    busy_after = 0;
    lin1       = 32'd0;
    lin2       = 32'd0;
    for (int k = 1; k <= 60 && vcnt < 2; k++) begin
      @(negedge clk);
      if (k == k1 + 1 && k1 > 0) busy_after = int'(busy);
      if (valid_out) begin
        vcnt++;
        if (vcnt == 1) begin
          k1        = k;
          lin1      = lin_out;
          db_in     = 32'h1E00_0000;
          enable_in = 1'b1;
        end else begin
          k2        = k;
          lin2      = lin_out;
          enable_in = 1'b0;
        end
      end else begin
        enable_in = 1'b0;
      end
    end
    enable_in = 1'b0;
    chk("b2b_first_lin", {32'd0, lin1}, 64'd100);
    chk("b2b_first_latency", 64'(k1), 64'd19);
    chk("b2b_busy_next_cycle", 64'(busy_after), 64'd1);
    chk("b2b_second_gap", 64'(k2 - k1), 64'd19);
    chk("b2b_second_lin", {32'd0, lin2}, 64'd1000);

    // Reset in the middle of EXP aborts without valid_out.
    @(negedge clk);
    db_in     = 32'h0A00_0000;
    enable_in = 1'b1;
    @(posedge clk);
    #1;
    enable_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, valid_out}, 64'd0);
    chk("abort_lin", {32'd0, lin_out}, 64'd0);
    vcnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (valid_out) vcnt++;
    end
    chk("abort_no_valid", 64'(vcnt), 64'd0);
    run_conv(32'h1E00_0000, lin, lat, bcnt);
    chk("after_abort_lin", {32'd0, lin}, 64'd1000);
    chk("after_abort_latency", 64'(lat), 64'd19);

    // Sweep 0..96 dB in 0.25 dB steps against the real-valued model.
    for (int q = 0; q <= 384; q++) begin
      run_conv(32'(q) * 32'd4194304, lin, lat, bcnt);
      y     = real'(q) * 0.25;
      ideal = $pow(10.0, y / 10.0);
      tol   = (ideal < 16.0) ? 1.0 : (ideal * (1.0 / 16384.0) + 0.5);
      diff  = real'(lin) - ideal;
      if (diff < 0.0) diff = -diff;
      ok = (lat == 19) && (diff <= tol);
      chk($sformatf("sweep_q%0d", q), {63'd0, ok}, 64'd1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/db_to_linear.md
Name: db_to_linear

Overview:
- Inverse of the 10*log10 dB block: converts an unsigned Q8.24 dB value y to the integer linear power x = round(10^(y/10)).
- Method: x = 2^t, where t = y*log2(10)/10. Split t into integer n and fraction f; compute 2^f by iterative multiplication over the fraction bits; shift the result by n.
- Sits on the power-control path after the dB-domain arithmetic. Multi-cycle and non-pipelined, with the same enable_in/valid_out handshake as the dB block.

Parameters:
- WIDTH, 32, input Q8.24 width and output integer width (only 32 is supported).
- FRAC_ITERS, 16, number of MSB fraction bits of t used in the 2^f iteration (range 8..24).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- db_in  input  WIDTH  dB value, Q8.24 unsigned (0.0 .. 255.99999994 dB).
- enable_in  input  1  start request; sampled only when not busy.
- busy  output  1  high while a conversion is in flight.
- valid_out  output  1  one-cycle pulse; lin_out is valid in that cycle.
- lin_out  output  WIDTH  linear power, unsigned integer, saturating at 0xFFFFFFFF.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0; valid_out=0; lin_out=0.
  - All internal registers cleared.
  - Reset asserted mid-conversion aborts it with no valid_out.
- States: IDLE, SCALE, EXP, NORM, DONE.
- IDLE / DONE:
  - If enable_in=1, capture db_in and go to SCALE. Otherwise go to (or stay in) IDLE.
  - DONE lasts exactly one cycle and drives valid_out=1.
  - An enable_in in DONE starts a new conversion back-to-back.
- SCALE (1 cycle):
  - p = db_reg * K, where K = round(log2(10)/10 * 2^24) = 5573271 (Q0.24). p is 56 bits.
  - t = p[55:24] (Q8.24); n = t[31:24]; f = t[23:0].
  - acc = 1.0 in Q2.30 (0x40000000); iteration index i = 1.
- EXP (FRAC_ITERS cycles, i = 1..FRAC_ITERS):
  - If f[24-i]=1: acc = (acc * C[i] + 2^29) >> 30.
  - C[i] = round(2^(2^-i) * 2^30), taken from a constant LUT.
  - acc stays in [1.0, 2.0), so it never exceeds 31 significant bits.
- NORM (1 cycle):
  - If n >= 32: lin_out = 0xFFFFFFFF.
  - Else: r = ((acc << n) + 2^29) >> 30, computed in 64 bits. lin_out = r if r < 2^32, else 0xFFFFFFFF.
- Latency: enable sampled at edge E0 → valid_out high in the cycle after edge E0+FRAC_ITERS+2 (19 cycles for the default).
- busy = 1 in SCALE, EXP and NORM; 0 in IDLE and DONE.
- enable_in while busy=1 is ignored; there is no queueing and no error flag.
- lin_out holds its last value until the next NORM; it is not cleared when valid_out drops.
- Accuracy: relative error <= 2^-14 versus ideal 10^(y/10) for outputs >= 16. Outputs below 16 are within ±1 LSB.
- db_in = 0 gives exactly 1. There is no zero output; the minimum is 1.

Decomposition:
- Shared package db_pkg holds:
  - Q-format widths (INT_W=8, FRAC_W=24, ACC_FRAC=30).
  - K_LOG2_10_DIV10 = 5573271.
  - The C[1..24] LUT as a constant function or array.
  - The state enum.
  - The saturation constant.
- One sub-module, exp2_frac_iter: owns acc, the iteration counter and the LUT multiply. Interface: start/done/f/acc. The top owns the FSM, scaling and normalisation.

Test Plan:
- db_in=0x00000000, enable 1 cycle → valid_out exactly 19 cycles later, lin_out=1, busy high for 18 cycles.
- db_in=30.0 (0x1E000000) → lin_out=1000. db_in=3.0103 (0x0302A305) → lin_out=2.
- db_in=96.0 (0x60000000) → lin_out within 3981071706 ± 2^-14 relative. db_in=100.0 (0x64000000) → lin_out=0xFFFFFFFF (saturated).
- Sweep db_in 0..96 dB in 0.25 dB steps against a real-valued model → all results within the stated tolerance; round-trip through the 10*log10 block stays within ±0.001 dB.
- Pulse enable_in at cycles 3 and 10 of a conversion → second pulse ignored, one valid_out. Enable in the DONE cycle → second conversion starts immediately, valid 19 cycles later.
- Assert rst for 1 cycle during EXP → next cycle busy=0, valid_out=0, lin_out=0. A new enable afterwards converts correctly.
